// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter that lends a single RGB LED to NUM_REQ requesters.
// Each winner shows its colour for its duration, then the LED is blanked for GAP_CYCLES.
module rgb_led_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DUR_WIDTH  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [3*NUM_REQ-1:0]           req_color,
  input  logic [DUR_WIDTH*NUM_REQ-1:0]   req_dur,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           red,
  output logic                           green,
  output logic                           blue
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [PW-1:0]          r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0]     r_sel_oh, w_sel_oh_nxt;
  logic [2:0]             r_color, w_color_nxt;
  logic [DUR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [GW-1:0]          r_gap, w_gap_nxt;
  logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]     r_done, w_done_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [2:0]             r_rgb, w_rgb_nxt;

  logic [2:0]             w_col [NUM_REQ];
  logic [DUR_WIDTH-1:0]   w_dur [NUM_REQ];
  logic                   w_found;
  logic [PW-1:0]          w_win;
  logic [NUM_REQ-1:0]     w_win_oh;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_col[i] = req_color[3*i +: 3];
      w_dur[i] = req_dur[DUR_WIDTH*i +: DUR_WIDTH];
    end
  end

  // Round-robin search: first requester at or above the pointer, else the first from zero.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (PW'(i) >= r_ptr)) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    end
    w_win_oh = NUM_REQ'(1) << w_win;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_sel_oh_nxt = r_sel_oh;
    w_color_nxt  = r_color;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap;
    w_gnt_nxt    = '0;
    w_done_nxt   = '0;
    w_rgb_nxt    = 3'b000;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_SHOW;
          w_ptr_nxt    = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
          w_sel_oh_nxt = w_win_oh;
          w_color_nxt  = w_col[w_win];
          // Counter holds the SHOW cycles remaining after this one; D=0 behaves as D=1.
          w_cnt_nxt    = (w_dur[w_win] == '0) ? '0 : w_dur[w_win] - DUR_WIDTH'(1);
          w_gnt_nxt    = w_win_oh;
          w_rgb_nxt    = w_col[w_win];
        end
      end
      S_SHOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GW'(GAP_CYCLES - 1);
          w_done_nxt  = r_sel_oh;
        end else begin
          w_cnt_nxt = r_cnt - DUR_WIDTH'(1);
          w_rgb_nxt = r_color;
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - GW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_sel_oh <= '0;
      r_color  <= 3'b000;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_rgb    <= 3'b000;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sel_oh <= w_sel_oh_nxt;
      r_color  <= w_color_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gap    <= w_gap_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_rgb    <= w_rgb_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = r_busy;
  assign red   = r_rgb[2];
  assign green = r_rgb[1];
  assign blue  = r_rgb[0];

endmodule
